cut_bist_controller: RTL and testbench

//   Sequences built-in self-test of the c5315 wrapper (in_val[177:0] -> out_val[122:0]) for Trojan screening.
//   Per pattern: drives an LFSR-generated vector onto the wrapper input, waits a settle window, then folds the

---
 rtl/bist_pkg.sv | 28 ++
 rtl/bist_shift_xor.sv | 20 ++
 rtl/cut_bist_controller.sv | 134 +++++++++++++
 tb/tb_cut_bist_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_pkg
// Brief    : Shared state encoding, widths and default polynomials for the
//            c5315 wrapper BIST controller.
// Revision : 1.0
// ============================================================================
package bist_pkg;

    localparam int BIST_IN_W  = 178;
    localparam int BIST_OUT_W = 123;
    localparam int BIST_CNT_W = 16;

    // x^178 + x^87 + 1 and x^123 + x^2 + 1
    localparam logic [BIST_IN_W-1:0]  BIST_LFSR_TAPS =
        (BIST_IN_W'(1) << 177) | (BIST_IN_W'(1) << 86);
    localparam logic [BIST_OUT_W-1:0] BIST_MISR_TAPS =
        (BIST_OUT_W'(1) << 122) | (BIST_OUT_W'(1) << 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } bist_state_t;

endpackage : bist_pkg
`default_nettype wire

// File: rtl/bist_shift_xor.sv
`default_nettype none
// ============================================================================
// Module   : bist_shift_xor
// Brief    : Combinational next value of a Fibonacci shift register with an
//            injection word: {x[W-2:0], ^(x & TAPS)} ^ inj.
// Revision : 1.0
// ============================================================================
module bist_shift_xor #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   TAPS = '0
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_inj,
    output logic [W-1:0] o_nxt
);

    assign o_nxt = {i_x[W-2:0], ^(i_x & TAPS)} ^ i_inj;

endmodule : bist_shift_xor
`default_nettype wire

// File: rtl/cut_bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : cut_bist_controller
// Brief    : LFSR-driven BIST sequencer for the c5315 wrapper; folds each
//            settled response into a MISR and compares against a golden value.
// Revision : 1.0
// ============================================================================
module cut_bist_controller
    import bist_pkg::*;
#(
    parameter int                IN_W       = BIST_IN_W,
    parameter int                OUT_W      = BIST_OUT_W,
    parameter int                CNT_W      = BIST_CNT_W,
    parameter int                SETTLE_CYC = 2,
    parameter logic [IN_W-1:0]   LFSR_TAPS  = BIST_LFSR_TAPS,
    parameter logic [OUT_W-1:0]  MISR_TAPS  = BIST_MISR_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [IN_W-1:0]   seed,
    input  logic [OUT_W-1:0]  golden_sig,
    output logic [IN_W-1:0]   cut_in,
    input  logic [OUT_W-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [OUT_W-1:0]  signature,
    output logic [CNT_W-1:0]  pattern_idx
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    bist_state_t          r_state;
    bist_state_t          w_state_nxt;
    logic [IN_W-1:0]      r_lfsr;
    logic [IN_W-1:0]      w_lfsr_nxt;
    logic [OUT_W-1:0]     r_misr;
    logic [OUT_W-1:0]     w_misr_nxt;
    logic [OUT_W-1:0]     r_golden;
    logic [OUT_W-1:0]     r_signature;
    logic [CNT_W-1:0]     r_num;
    logic [CNT_W-1:0]     r_idx;
    logic [SETTLE_W-1:0]  r_settle;
    logic                 r_pass;
    logic                 w_last_settle;
    logic                 w_last_pattern;

    bist_shift_xor #(.W(IN_W), .TAPS(LFSR_TAPS)) u_lfsr_nxt (
        .i_x   (r_lfsr),
        .i_inj ('0),
        .o_nxt (w_lfsr_nxt)
    );

    bist_shift_xor #(.W(OUT_W), .TAPS(MISR_TAPS)) u_misr_nxt (
        .i_x   (r_misr),
        .i_inj (cut_out),
        .o_nxt (w_misr_nxt)
    );

    assign w_last_settle  = (r_settle == SETTLE_W'(SETTLE_CYC - 1));
    // Widened compare so N = 2^CNT_W-1 never sees a wrapped count.
    assign w_last_pattern = (({1'b0, r_idx} + (CNT_W+1)'(1)) == {1'b0, r_num});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (num_patterns == '0) ? DONE : APPLY;
            APPLY:   if (w_last_settle) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = w_last_pattern ? DONE : APPLY;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= '0;
            r_misr      <= '0;
            r_golden    <= '0;
            r_signature <= '0;
            r_num       <= '0;
            r_idx       <= '0;
            r_settle    <= '0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_num       <= num_patterns;
                        r_golden    <= golden_sig;
                        r_lfsr      <= seed;
                        r_misr      <= '0;
                        r_idx       <= '0;
                        r_settle    <= '0;
                        r_signature <= '0;
                        r_pass      <= (num_patterns == '0) && (golden_sig == '0);
                    end
                end
                APPLY: begin
                    r_settle <= w_last_settle ? '0 : r_settle + SETTLE_W'(1);
                end
                CAPTURE: begin
                    r_misr <= w_misr_nxt;
                    r_lfsr <= w_lfsr_nxt;
                    r_idx  <= r_idx + CNT_W'(1);
                    if (w_last_pattern) begin
                        r_signature <= w_misr_nxt;
                        r_pass      <= (w_misr_nxt == r_golden);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cut_in      = r_lfsr;
    assign busy        = (r_state == APPLY) || (r_state == CAPTURE);
    assign done        = (r_state == DONE);
    assign pass        = r_pass;
    assign signature   = r_signature;
    assign pattern_idx = r_idx;

endmodule : cut_bist_controller
`default_nettype wire

// File: tb/tb_cut_bist_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cut_bist_controller
// Brief    : Randomized self-checking bench for cut_bist_controller against a
//            cycle-indexed behavioural model of the BIST run.
// Revision : 1.0
// ============================================================================
module tb_cut_bist_controller;

    localparam int IN_W       = 178;
    localparam int OUT_W      = 123;
    localparam int CNT_W      = 16;
    localparam int SETTLE_CYC = 2;
    localparam int PER        = SETTLE_CYC + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_patterns;
    logic [IN_W-1:0]   seed;
    logic [OUT_W-1:0]  golden_sig;
    logic [IN_W-1:0]   cut_in;
    logic [OUT_W-1:0]  cut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [OUT_W-1:0]  signature;
    logic [CNT_W-1:0]  pattern_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cut_bist_controller #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .seed         (seed),
        .golden_sig   (golden_sig),
        .cut_in       (cut_in),
        .cut_out      (cut_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .pattern_idx  (pattern_idx)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Polynomial x^178+x^87+1: new bit 0 is the XOR of bits 177 and 86.
    function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] x);
        return (x << 1) | IN_W'(x[177] ^ x[86]);
    endfunction

    // Polynomial x^123+x^2+1 with the response folded in.
    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m, input logic [OUT_W-1:0] r);
        return ((m << 1) | OUT_W'(m[122] ^ m[1])) ^ r;
    endfunction

    // Stand-in for the wrapper: an arbitrary fixed mixing of the vector.
    function automatic logic [OUT_W-1:0] stub(input logic [IN_W-1:0] v);
        return v[122:0] ^ {v[177:123], v[67:0]} ^ {v[60:0], v[177:116]};
    endfunction

    function automatic logic [IN_W-1:0] rnd_in();
        return IN_W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic logic [OUT_W-1:0] rnd_out();
        return OUT_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic run(input string name, input int n, input logic [IN_W-1:0] sd,
                       input logic use_const, input logic [OUT_W-1:0] cval,
                       input logic flip_gold, input int repulse_k, input logic noisy);
        logic [IN_W-1:0]  vec[$];
        logic [IN_W-1:0]  v;
        logic [OUT_W-1:0] m;
        logic [OUT_W-1:0] gold;
        logic             exp_pass;
        int               last_k;
        v = sd;
        m = '0;
        for (int p = 0; p < n; p++) begin
            vec.push_back(v);
            m = misr_step(m, use_const ? cval : stub(v));
            v = lfsr_step(v);
        end
        gold = m;
        if (flip_gold) begin
            int b;
            b = $urandom_range(OUT_W - 1);
            gold[b] = ~gold[b];
        end
        exp_pass = (gold == m);
        last_k   = (n == 0) ? 0 : PER * n;

        @(negedge clk);
        start        = 1'b1;
        num_patterns = CNT_W'(n);
        seed         = sd;
        golden_sig   = gold;
        cut_out      = use_const ? cval : rnd_out();
        @(posedge clk);
        for (int k = 0; k <= last_k + 2; k++) begin
            @(negedge clk);
            if (k < last_k) begin
                check({name, ":busy"}, 256'(busy), 256'(1));
                check({name, ":done"}, 256'(done), 256'(0));
                check({name, ":cut_in"}, 256'(cut_in), 256'(vec[k / PER]));
                check({name, ":idx"}, 256'(pattern_idx), 256'(k / PER));
            end else begin
                check({name, k == last_k ? ":done_hi" : ":done_lo"}, 256'(done), 256'(k == last_k));
                check({name, ":busy_off"}, 256'(busy), 256'(0));
                check({name, ":sig"}, 256'(signature), 256'(m));
                check({name, ":pass"}, 256'(pass), 256'(exp_pass));
                check({name, ":idx_end"}, 256'(pattern_idx), 256'(n));
                check({name, ":cut_in_end"}, 256'(cut_in), 256'(v));
            end
            start = 1'b0;
            if (k <= last_k) begin
                if (noisy && (k == last_k || $urandom_range(3) == 0)) begin
                    start        = 1'b1;
                    num_patterns = CNT_W'($urandom);
                    seed         = rnd_in();
                    golden_sig   = ~gold;
                end
                if (k == repulse_k) begin
                    start = 1'b1;
                    seed  = IN_W'(7);
                end
            end
            if (use_const)
                cut_out = cval;
            else if (k < last_k && (k % PER) == PER - 1)
                cut_out = stub(vec[k / PER]);
            else
                cut_out = rnd_out();
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_patterns = '0;
        seed         = '0;
        golden_sig   = '0;
        cut_out      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset:cut_in", 256'(cut_in), 256'(0));
        check("reset:busy", 256'(busy), 256'(0));
        check("reset:done", 256'(done), 256'(0));
        check("reset:pass", 256'(pass), 256'(0));
        check("reset:sig", 256'(signature), 256'(0));
        check("reset:idx", 256'(pattern_idx), 256'(0));
        rst = 1'b0;

        run("n1_const5", 1, IN_W'(1), 1'b1, OUT_W'(5), 1'b0, -1, 1'b0);
        run("n2_const1", 2, IN_W'(1), 1'b1, OUT_W'(1), 1'b1, -1, 1'b0);
        run("n0", 0, rnd_in(), 1'b0, '0, 1'b0, -1, 1'b0);
        run("n3_repulse", 3, IN_W'(1), 1'b1, '0, 1'b0, 1, 1'b0);

        // Abort: reset mid-run must clear everything without a done pulse.
        @(negedge clk);
        start        = 1'b1;
        num_patterns = CNT_W'(5);
        seed         = rnd_in();
        golden_sig   = rnd_out();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort:cut_in", 256'(cut_in), 256'(0));
        check("abort:busy", 256'(busy), 256'(0));
        check("abort:done", 256'(done), 256'(0));
        check("abort:idx", 256'(pattern_idx), 256'(0));
        check("abort:sig", 256'(signature), 256'(0));
        check("abort:pass", 256'(pass), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort:idle_done", 256'(done), 256'(0));
            check("abort:idle_busy", 256'(busy), 256'(0));
        end
        run("after_abort", 1, rnd_in(), 1'b0, '0, 1'b0, -1, 1'b0);

        run("n100_good", 100, rnd_in(), 1'b0, '0, 1'b0, -1, 1'b0);
        run("n100_flip", 100, rnd_in(), 1'b0, '0, 1'b1, -1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run($sformatf("rand%0d", i), int'($urandom_range(25)),
                (i == 0) ? '0 : rnd_in(), 1'b0, '0, 1'($urandom_range(1)), -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cut_bist_controller
`default_nettype wire
